// File: rtl/ignition_angle_tracker_pkg.sv
// Shared EFI encodings: stroke phases, tracker states, build config.
// Also read by ignition_control.
`ifndef CFG_CYLINDERS
`define CFG_CYLINDERS 4
`endif
`ifndef CFG_TEETH_PER_REV
`define CFG_TEETH_PER_REV 36
`endif

package ignition_angle_tracker_pkg;

  localparam int CFG_CYLINDERS = `CFG_CYLINDERS;
  localparam int CFG_HALF_REV  = `CFG_TEETH_PER_REV / 2;

  typedef enum logic [1:0] {
    STROKE_INTAKE      = 2'b00,
    STROKE_COMPRESSION = 2'b01,
    STROKE_COMBUSTION  = 2'b10,
    STROKE_EXHAUST     = 2'b11
  } stroke_e;

  typedef enum logic [2:0] {
    TRK_IDLE  = 3'd0,
    TRK_ARMED = 3'd1,
    TRK_COUNT = 3'd2,
    TRK_READY = 3'd3,
    TRK_DONE  = 3'd4
  } trk_state_e;

endpackage

// File: rtl/ignition_angle_tracker_edge.sv
// Registers the stroke phase and flags entry into
// compression and exhaust.
module stroke_edge_detect
  import ignition_angle_tracker_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [1:0] stroke_i,
  output logic       comp_start_o,
  output logic       exhaust_start_o
);

  logic [1:0] stroke_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stroke_q <= STROKE_EXHAUST;
    else          stroke_q <= stroke_i;
  end

  assign comp_start_o =
    (stroke_i == STROKE_COMPRESSION) &&
    (stroke_q != STROKE_COMPRESSION);
  assign exhaust_start_o =
    (stroke_i == STROKE_EXHAUST) &&
    (stroke_q != STROKE_EXHAUST);

endmodule

// File: rtl/ignition_angle_tracker.sv
// Tracks crank angle through compression and flags the
// per-cylinder advance point for the ignition FSM.
module ignition_angle_tracker
  import ignition_angle_tracker_pkg::*;
#(
  parameter int CYLINDERS       = CFG_CYLINDERS,
  parameter int ANGLE_W         = 8,
  parameter int HALF_REV_TICKS  = CFG_HALF_REV,
  parameter int MAX_ADVANCE     = 15,
  parameter int DEFAULT_ADVANCE = 1,
  parameter int CYL_W =
    (CYLINDERS > 1) ? $clog2(CYLINDERS) : 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 on,
  input  logic [1:0]           stroke,
  input  logic                 crank_tick,
  input  logic                 cal_ignition,
  input  logic [ANGLE_W-1:0]   advance_ticks,
  input  logic [CYL_W-1:0]     cyl_idx,
  input  logic                 ignite,
  output logic [CYLINDERS-1:0] btdc_ready,
  output logic [ANGLE_W-1:0]   tick_count,
  output logic                 adv_clamped,
  output logic                 missed_cal
);

  localparam logic [ANGLE_W-1:0] MAX_A = ANGLE_W'(MAX_ADVANCE);
  localparam logic [ANGLE_W-1:0] DEF_A = ANGLE_W'(DEFAULT_ADVANCE);
  localparam logic [ANGLE_W-1:0] HALF  = ANGLE_W'(HALF_REV_TICKS);

  trk_state_e           state_q, state_d;
  logic [ANGLE_W-1:0]   adv_q, adv_d;
  logic                 advv_q, advv_d;
  logic [CYL_W-1:0]     cyl_q, cyl_d;
  logic [ANGLE_W-1:0]   tick_q, tick_d;
  logic [CYLINDERS-1:0] rdy_q, rdy_d;
  logic                 clamp_q, clamp_d;
  logic                 miss_q, miss_d;

  logic                 comp_start, exh_start;
  logic                 over, can_latch, in_comp, exh_now;
  logic [ANGLE_W-1:0]   lat_val, tick_inc, target;

  stroke_edge_detect u_edge (
    .clk             (clk),
    .reset_n         (reset_n),
    .stroke_i        (stroke),
    .comp_start_o    (comp_start),
    .exhaust_start_o (exh_start)
  );

  assign over      = advance_ticks > MAX_A;
  assign lat_val   = over ? MAX_A : advance_ticks;
  assign tick_inc  = tick_q + 1'b1;
  assign target    = HALF - adv_q;
  assign in_comp   = stroke == STROKE_COMPRESSION;
  assign exh_now   = exh_start || (stroke == STROKE_EXHAUST);
  assign can_latch = cal_ignition && !advv_q &&
    ((state_q == TRK_IDLE) || (state_q == TRK_ARMED));

  always_comb begin
    state_d = state_q;
    adv_d   = adv_q;
    advv_d  = advv_q;
    cyl_d   = cyl_q;
    tick_d  = tick_q;
    rdy_d   = rdy_q;
    clamp_d = clamp_q;
    miss_d  = miss_q;
    if (!on) begin
      state_d = TRK_IDLE;
      rdy_d   = '0;
      tick_d  = '0;
      advv_d  = 1'b0;
    end else begin
      if (can_latch) begin
        adv_d  = lat_val;
        advv_d = 1'b1;
        if (over) clamp_d = 1'b1;
      end
      unique case (state_q)
        TRK_IDLE: state_d = TRK_ARMED;
        TRK_ARMED: begin
          if (comp_start) begin
            if (!advv_q && !cal_ignition) begin
              adv_d  = DEF_A;
              miss_d = 1'b1;
            end
            cyl_d   = cyl_idx;
            tick_d  = '0;
            state_d = TRK_COUNT;
          end
        end
        TRK_COUNT: begin
          // stroke ended before the advance point
          if (!in_comp) begin
            state_d = TRK_DONE;
          end else if (crank_tick) begin
            tick_d = tick_inc;
            if (tick_inc == target) begin
              rdy_d   = CYLINDERS'(1) << cyl_q;
              state_d = TRK_READY;
            end
          end
        end
        TRK_READY: begin
          if (crank_tick && (tick_q < HALF))
            tick_d = tick_inc;
          if (ignite || !in_comp) begin
            rdy_d   = '0;
            state_d = TRK_DONE;
          end
        end
        TRK_DONE: begin
          if (exh_now) begin
            advv_d  = 1'b0;
            clamp_d = 1'b0;
            miss_d  = 1'b0;
            state_d = TRK_ARMED;
          end
        end
        default: state_d = TRK_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= TRK_IDLE;
      adv_q   <= DEF_A;
      advv_q  <= 1'b0;
      cyl_q   <= '0;
      tick_q  <= '0;
      rdy_q   <= '0;
      clamp_q <= 1'b0;
      miss_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      adv_q   <= adv_d;
      advv_q  <= advv_d;
      cyl_q   <= cyl_d;
      tick_q  <= tick_d;
      rdy_q   <= rdy_d;
      clamp_q <= clamp_d;
      miss_q  <= miss_d;
    end
  end

  assign btdc_ready  = rdy_q;
  assign tick_count  = tick_q;
  assign adv_clamped = clamp_q;
  assign missed_cal  = miss_q;

endmodule
